// File: rtl/rasterize_triangle.sv
// rasterize_triangle: scans the clamped bounding box of one screen-space
// triangle in row-major order and emits one flat-depth fragment per pixel
// whose centre-less integer coordinate lies inside (or on) all three edges.
module rasterize_triangle #(
    parameter int COORD_WIDTH = 32,
    parameter int FB_WIDTH    = 320,
    parameter int FB_HEIGHT   = 180
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   start,
    input  logic                                   tri_valid,
    input  logic signed [2:0][2:0][COORD_WIDTH-1:0] tri_verts,
    output logic [15:0]                            pixel_x,
    output logic [15:0]                            pixel_y,
    output logic signed [COORD_WIDTH-1:0]          pixel_z,
    output logic                                   pixel_valid,
    input  logic                                   pixel_ready,
    output logic                                   busy,
    output logic                                   done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        AREA,
        SCAN,
        EMIT,
        DONE
    } state_t;

    localparam logic signed [16:0] X_LAST = 17'(FB_WIDTH - 1);
    localparam logic signed [16:0] Y_LAST = 17'(FB_HEIGHT - 1);

    // Sign-extend a 16-bit integer coordinate to the 17-bit scan domain.
    function automatic logic signed [16:0] sx17(input logic [15:0] v);
        return $signed({v[15], v});
    endfunction

    // Edge function of edge a->b evaluated at point q. Operands are 16-bit
    // so every difference fits 17 bits and every product/sum fits 34 bits.
    function automatic logic signed [33:0] edge_fn(
        input logic [15:0]        ax,
        input logic [15:0]        ay,
        input logic [15:0]        bx,
        input logic [15:0]        by,
        input logic signed [16:0] qx,
        input logic signed [16:0] qy
    );
        logic signed [16:0] dx, dy, rx, ry;
        logic signed [33:0] p0, p1;
        dx = sx17(bx) - sx17(ax);
        dy = sx17(by) - sx17(ay);
        rx = qx - sx17(ax);
        ry = qy - sx17(ay);
        p0 = 34'(dx) * 34'(ry);
        p1 = 34'(dy) * 34'(rx);
        return p0 - p1;
    endfunction

    state_t                              state_q;
    logic [2:0][15:0]                    xi_q;
    logic [2:0][15:0]                    yi_q;
    logic [2:0][COORD_WIDTH-1:0]         z_q;
    logic signed [16:0]                  minx_q, maxx_q, miny_q, maxy_q;
    logic signed [COORD_WIDTH-1:0]       zmin_q;
    logic                                area_neg_q;
    logic signed [16:0]                  px_q, py_q;
    logic [15:0]                         pix_x_q, pix_y_q;
    logic signed [COORD_WIDTH-1:0]       pix_z_q;
    logic                                pix_valid_q;
    logic                                busy_q;
    logic                                done_q;

    logic signed [16:0]                  bb_minx_d, bb_maxx_d, bb_miny_d, bb_maxy_d;
    logic signed [COORD_WIDTH-1:0]       zmin_d;
    logic signed [33:0]                  area_d;
    logic signed [33:0]                  edge_val [3];
    logic                                inside_d;
    logic signed [16:0]                  px_d, py_d;
    logic                                scan_last_d;

    // Only the integer part of x/y is used; the fractional bits are floored away.
    logic unused_frac;
    assign unused_frac = ^{tri_verts[0][0][COORD_WIDTH-17:0], tri_verts[0][1][COORD_WIDTH-17:0],
                           tri_verts[1][0][COORD_WIDTH-17:0], tri_verts[1][1][COORD_WIDTH-17:0],
                           tri_verts[2][0][COORD_WIDTH-17:0], tri_verts[2][1][COORD_WIDTH-17:0]};

    // Bounding box of the integer vertices, one-sided clamped so an off-screen
    // triangle yields min>max, and the flat depth (signed min of z).
    always_comb begin
        logic signed [15:0] mnx, mxx, mny, mxy;
        mnx    = $signed(xi_q[0]);
        mxx    = $signed(xi_q[0]);
        mny    = $signed(yi_q[0]);
        mxy    = $signed(yi_q[0]);
        zmin_d = $signed(z_q[0]);
        for (int i = 1; i < 3; i++) begin
            if ($signed(xi_q[i]) < mnx) mnx = $signed(xi_q[i]);
            if ($signed(xi_q[i]) > mxx) mxx = $signed(xi_q[i]);
            if ($signed(yi_q[i]) < mny) mny = $signed(yi_q[i]);
            if ($signed(yi_q[i]) > mxy) mxy = $signed(yi_q[i]);
            if ($signed(z_q[i]) < zmin_d) zmin_d = $signed(z_q[i]);
        end
        bb_minx_d = (mnx < 16'sd0) ? 17'sd0 : sx17(mnx);
        bb_miny_d = (mny < 16'sd0) ? 17'sd0 : sx17(mny);
        bb_maxx_d = (sx17(mxx) > X_LAST) ? X_LAST : sx17(mxx);
        bb_maxy_d = (sx17(mxy) > Y_LAST) ? Y_LAST : sx17(mxy);
    end

    // Twice the signed area is edge 0 evaluated at vertex 2.
    assign area_d = edge_fn(xi_q[0], yi_q[0], xi_q[1], yi_q[1], sx17(xi_q[2]), sx17(yi_q[2]));

    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
        localparam int NXT = (gi + 1) % 3;
        assign edge_val[gi] = edge_fn(xi_q[gi], yi_q[gi], xi_q[NXT], yi_q[NXT], px_q, py_q);
    end

    // Coverage: each edge is zero or shares the area's sign, so either winding works.
    always_comb begin
        inside_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if ((edge_val[i] != 34'sd0) && (edge_val[i][33] != area_neg_q)) inside_d = 1'b0;
        end
    end

    // Next raster position, wrapping to the next row; flags the final pixel.
    always_comb begin
        px_d        = px_q + 17'sd1;
        py_d        = py_q;
        scan_last_d = 1'b0;
        if (px_q >= maxx_q) begin
            px_d        = minx_q;
            py_d        = py_q + 17'sd1;
            scan_last_d = (py_q >= maxy_q);
        end
    end

    // Control FSM with registered fragment/status outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            xi_q        <= '0;
            yi_q        <= '0;
            z_q         <= '0;
            minx_q      <= '0;
            maxx_q      <= '0;
            miny_q      <= '0;
            maxy_q      <= '0;
            zmin_q      <= '0;
            area_neg_q  <= 1'b0;
            px_q        <= '0;
            py_q        <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_z_q     <= '0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 3; i++) begin
                            xi_q[i] <= tri_verts[i][0][COORD_WIDTH-1 -: 16];
                            yi_q[i] <= tri_verts[i][1][COORD_WIDTH-1 -: 16];
                            z_q[i]  <= tri_verts[i][2];
                        end
                        busy_q  <= 1'b1;
                        state_q <= tri_valid ? SETUP : DONE;
                    end
                end
                SETUP: begin
                    minx_q  <= bb_minx_d;
                    maxx_q  <= bb_maxx_d;
                    miny_q  <= bb_miny_d;
                    maxy_q  <= bb_maxy_d;
                    zmin_q  <= zmin_d;
                    state_q <= ((bb_minx_d > bb_maxx_d) || (bb_miny_d > bb_maxy_d)) ? DONE : AREA;
                end
                AREA: begin
                    if (area_d == 34'sd0) begin
                        state_q <= DONE;
                    end else begin
                        area_neg_q <= area_d[33];
                        px_q       <= minx_q;
                        py_q       <= miny_q;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    if (inside_d) begin
                        pix_x_q     <= px_q[15:0];
                        pix_y_q     <= py_q[15:0];
                        pix_z_q     <= zmin_q;
                        pix_valid_q <= 1'b1;
                        state_q     <= EMIT;
                    end else if (scan_last_d) begin
                        state_q <= DONE;
                    end else begin
                        px_q <= px_d;
                        py_q <= py_d;
                    end
                end
                EMIT: begin
                    if (pixel_ready) begin
                        pix_valid_q <= 1'b0;
                        if (scan_last_d) begin
                            state_q <= DONE;
                        end else begin
                            px_q    <= px_d;
                            py_q    <= py_d;
                            state_q <= SCAN;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pixel_x     = pix_x_q;
    assign pixel_y     = pix_y_q;
    assign pixel_z     = pix_z_q;
    assign pixel_valid = pix_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_rasterize_triangle.sv
// Bench for rasterize_triangle: expected fragments are queued per triangle
// from hand-derived coverage regions; a negedge monitor drives pixel_ready,
// pops the queue on each handshake and checks output stability while stalled.
module tb_rasterize_triangle;

    localparam int CW = 32;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] z;
    } frag_t;

    logic                      clk_in = 1'b0;
    logic                      rst_in = 1'b1;
    logic                      start = 1'b0;
    logic                      tri_valid = 1'b0;
    logic [2:0][2:0][CW-1:0]   tri_verts = '0;
    logic [15:0]               pixel_x;
    logic [15:0]               pixel_y;
    logic [CW-1:0]             pixel_z;
    logic                      pixel_valid;
    logic                      pixel_ready = 1'b0;
    logic                      busy;
    logic                      done;

    int    checks = 0;
    int    passes = 0;
    frag_t exp_q[$];
    int    ready_mode = 0;   // 0: always ready, 1: ~30% ready, 2: never ready
    int    frag_count = 0;
    logic  hold_pending = 1'b0;
    frag_t held;

    rasterize_triangle #(.COORD_WIDTH(CW), .FB_WIDTH(320), .FB_HEIGHT(180)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start       (start),
        .tri_valid   (tri_valid),
        .tri_verts   (tri_verts),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_z     (pixel_z),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] q(input int v);
        return 32'(v) << 16;
    endfunction

    function automatic logic [2:0][2:0][31:0] mkv(
        input logic [31:0] x0, input logic [31:0] y0, input logic [31:0] z0,
        input logic [31:0] x1, input logic [31:0] y1, input logic [31:0] z1,
        input logic [31:0] x2, input logic [31:0] y2, input logic [31:0] z2);
        logic [2:0][2:0][31:0] v;
        v[0][0] = x0; v[0][1] = y0; v[0][2] = z0;
        v[1][0] = x1; v[1][1] = y1; v[1][2] = z1;
        v[2][0] = x2; v[2][1] = y2; v[2][2] = z2;
        return v;
    endfunction

    // Region x in [xlo,xhi], y in [ylo,yhi], x+y <= sum, row-major.
    task automatic push_region(input int xlo, input int xhi, input int ylo, input int yhi,
                               input int sum, input logic [31:0] z, output int n);
        n = 0;
        for (int y = ylo; y <= yhi; y++) begin
            for (int x = xlo; x <= xhi; x++) begin
                if (x + y <= sum) begin
                    exp_q.push_back({16'(x), 16'(y), z});
                    n++;
                end
            end
        end
    endtask

    // Monitor: drives ready, scores handshakes, checks stall stability.
    always @(negedge clk_in) begin
        frag_t cur;
        frag_t e;
        cur = {pixel_x, pixel_y, pixel_z};
        if (rst_in) begin
            hold_pending = 1'b0;
        end else if (hold_pending) begin
            check("valid_held", 64'(pixel_valid), 64'd1);
            if (pixel_valid) check("stall_stable", cur, held);
        end
        case (ready_mode)
            0:       pixel_ready = 1'b1;
            1:       pixel_ready = ($urandom_range(0, 9) < 3);
            default: pixel_ready = 1'b0;
        endcase
        hold_pending = pixel_valid && !pixel_ready && !rst_in;
        held = cur;
        if (pixel_valid && pixel_ready && !rst_in) begin
            frag_count++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_frag: got x=%0d y=%0d z=%0h, none expected", pixel_x, pixel_y, pixel_z);
            end else begin
                e = exp_q.pop_front();
                check("frag", cur, e);
            end
        end
    end

    task automatic run_tri(input string name, input logic [2:0][2:0][31:0] v, input logic tv,
                           input int exp_n, input int exp_lat);
        int cyc;
        logic got;
        @(negedge clk_in);
        frag_count = 0;
        tri_verts  = v;
        tri_valid  = tv;
        start      = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (cyc < 4000) begin
            @(negedge clk_in);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                check({name, "_busy_high"}, 64'(busy), 64'd1);
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 64'(got), 64'd1);
        if (exp_lat > 0) check({name, "_done_latency"}, 64'(cyc), 64'(exp_lat));
        check({name, "_busy_low"}, 64'(busy), 64'd0);
        check({name, "_frag_count"}, 64'(frag_count), 64'(exp_n));
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk_in);
        check({name, "_done_pulse"}, 64'(done), 64'd0);
        $display("triangle %s: %0d fragments, done after %0d cycles", name, frag_count, cyc);
    endtask

    initial begin
        logic [2:0][2:0][31:0] v1;
        int n;
        int w;

        v1 = mkv(q(10), q(10), q(5), q(20), q(10), q(3), q(10), q(20), q(4));

        // Reset state
        repeat (2) @(negedge clk_in);
        check("reset_valid", 64'(pixel_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_pixel", {pixel_x, pixel_y, pixel_z}, 64'd0);
        rst_in = 1'b0;

        // Basic triangle, ccw
        push_region(10, 20, 10, 20, 30, 32'h0003_0000, n);
        run_tri("basic", v1, 1'b1, n, 0);

        // Opposite winding
        push_region(10, 20, 10, 20, 30, 32'h0003_0000, n);
        run_tri("swapped", mkv(q(10), q(10), q(5), q(10), q(20), q(4), q(20), q(10), q(3)), 1'b1, n, 0);

        // Degenerate and discarded
        run_tri("collinear", mkv(q(0), q(0), q(1), q(5), q(5), q(1), q(10), q(10), q(1)), 1'b1, 0, 4);
        run_tri("discarded", v1, 1'b0, 0, 2);

        // Clipped against x=0/y=0, fractional vertex floors to -10, negative zmin
        push_region(0, 30, 0, 30, 20, 32'hFFFE_0000, n);
        run_tri("clipped", mkv(q(-10) + 32'h8000, q(-10), q(1), q(30), q(-10), q(-2), q(-10), q(30), q(7)),
                1'b1, n, 0);

        // Entirely left of the screen
        run_tri("offscreen", mkv(q(-50), q(5), q(1), q(-20), q(5), q(1), q(-30), q(40), q(1)), 1'b1, 0, 3);

        // Back-pressure
        ready_mode = 1;
        push_region(10, 20, 10, 20, 30, 32'h0003_0000, n);
        run_tri("backpressure", v1, 1'b1, n, 0);

        // Asynchronous reset while a fragment is stalled
        ready_mode = 2;
        @(negedge clk_in);
        tri_verts = v1;
        tri_valid = 1'b1;
        start     = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        w = 0;
        while (!pixel_valid && w < 20) begin
            @(negedge clk_in);
            w++;
        end
        check("rst_reached_emit", 64'(pixel_valid), 64'd1);
        #2 rst_in = 1'b1;
        #1;
        check("rst_async_valid", 64'(pixel_valid), 64'd0);
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_async_done", 64'(done), 64'd0);
        $display("async reset applied during stalled fragment");
        @(negedge clk_in);
        #2 rst_in = 1'b0;
        ready_mode = 0;
        push_region(10, 20, 10, 20, 30, 32'h0003_0000, n);
        run_tri("after_reset", v1, 1'b1, n, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rasterize_triangle.md
Name: rasterize_triangle

Overview:
Consumes one projected triangle: three screen-space vertices in Q16.16 (x, y, z), as produced by the projection stage with its valid/done. Walks the clamped bounding box in row-major order and tests each integer pixel against three edge functions. Emits one fragment per covered pixel over a valid/ready handshake to the depth-test/framebuffer writer. Uses flat depth: the minimum vertex z.

Parameters:
COORD_WIDTH, 32, vertex component width; Q16.16 fixed point.
FB_WIDTH, 320, framebuffer width in pixels.
FB_HEIGHT, 180, framebuffer height in pixels.

Ports:
clk_in  input  1  clock
rst_in  input  1  reset; asynchronous, active-high
start  input  1  begin a triangle; sampled only in IDLE
tri_valid  input  1  upstream valid; 0 means the triangle was discarded
tri_verts  input  [2:0][2:0][COORD_WIDTH]  signed; [v][0]=x, [v][1]=y, [v][2]=z, Q16.16
pixel_x  output  16  fragment x, integer
pixel_y  output  16  fragment y, integer
pixel_z  output  COORD_WIDTH  fragment depth, Q16.16
pixel_valid  output  1  fragment present
pixel_ready  input  1  downstream accepts the fragment
busy  output  1  high from start accept until DONE exits
done  output  1  single-cycle completion pulse

Behaviour:
- Reset (asynchronous, any state, including mid-scan): state=IDLE. All outputs are 0. Internal counters clear.
- States: IDLE, SETUP, AREA, SCAN, EMIT, DONE.
- IDLE, start=1:
  - Latch tri_verts and tri_valid; busy<=1.
  - Go to SETUP, or to DONE if tri_valid=0.
  - start while busy is ignored.
- SETUP (1 cycle):
  - Integer coordinates xi/yi = bits [31:16] of each vertex (signed 16-bit floor).
  - bbox = min/max of xi, yi, clamped to [0, FB_WIDTH-1] × [0, FB_HEIGHT-1].
  - zmin = signed minimum of the three z values.
  - If minx>maxx or miny>maxy → DONE.
- AREA (1 cycle):
  - area = (x1-x0)(y2-y0) - (y1-y0)(x2-x0).
  - Arithmetic: 17-bit signed differences, 34-bit signed products/sums; no overflow is possible.
  - area==0 (degenerate) → DONE.
  - Otherwise record sign(area); px=minx, py=miny; go to SCAN.
- SCAN, one pixel per cycle:
  - E0 = (x1-x0)(py-y0) - (y1-y0)(px-x0).
  - E1, E2 are the same form for edges v1→v2 and v2→v0.
  - Inside iff every Ei is zero or has the sign of area. Both windings are accepted; edge pixels are included.
  - Inside: register pixel_x=px, pixel_y=py, pixel_z=zmin, pixel_valid<=1; go to EMIT.
  - Not inside: advance.
- Advance:
  - px++; if px>maxx then px=minx and py++.
  - If py>maxy after the wrap → DONE.
- EMIT:
  - Hold pixel_x/y/z and pixel_valid stable until pixel_ready=1.
  - On the handshake cycle, pixel_valid<=0, then advance (to SCAN or DONE).
  - pixel_valid never drops without a handshake.
- DONE: done=1 for exactly one cycle, busy<=0, then IDLE. start is accepted again on the following cycle.
- Timing:
  - Latency start→first SCAN evaluation = 3 cycles.
  - Covered pixels cost 2 cycles each with pixel_ready held high; uncovered pixels cost 1 cycle.
- Vertex z is never range-checked; pixel_x/pixel_y are always inside the framebuffer.

Test Plan:
- Verts (10,10),(20,10),(10,20), z=5.0/3.0/4.0, tri_valid=1, ready=1 → exactly 66 fragments, all with pixel_z=0x00030000. First fragment is (10,10), last is (10,20); row 10 contains x=10..20. One done pulse; busy low afterwards.
- Same triangle with v1 and v2 swapped (opposite winding) → the identical 66 fragments in the identical order.
- Collinear verts (0,0),(5,5),(10,10) → zero fragments; done asserted 4 cycles after start. Also tri_valid=0 → zero fragments; done 2 cycles after start.
- Verts (-10,-10),(30,-10),(-10,30) → 231 fragments covering x,y≥0 with x+y≤20; first is (0,0). Verts entirely at x<0 → zero fragments, done.
- Triangle from the first scenario with pixel_ready random at 30% high → pixel_x/y/z stable while valid && !ready; still 66 fragments, same order, no duplicates.
- Assert rst_in asynchronously mid-EMIT → pixel_valid, busy and done are 0 immediately. A new start after release rasterizes the first scenario correctly.
